// File: rtl/rr_pipe_arb_pkg.sv
// Shared definitions for the round-robin packet-lock arbiter:
// FSM state encodings and the cyclic index helper.
package rr_pipe_arb_pkg;

   // Arbiter FSM encodings.
   localparam logic [0:0] ARB_IDLE   = 1'b0;
   localparam logic [0:0] ARB_LOCKED = 1'b1;

   // Wide enough for any legal requester count (2..16).
   localparam int unsigned IDX_W = 5;

   // Cyclic successor: (idx + 1) mod num, valid for any num, not only powers of two.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                 input logic [IDX_W-1:0] num);
      logic [IDX_W-1:0] nxt;
      if (idx == (num - 5'd1)) begin
         nxt = 5'd0;
      end else begin
         nxt = idx + 5'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: finds the first set request at or after
// ptr, wrapping cyclically. The request vector is doubled so that a single
// lowest-set-bit search over the masked double-width vector covers the wrap.
module rr_arb_pick #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] ptr,
   output logic                found,
   output logic [ID_WIDTH-1:0] winner
);

   logic [2*NUM_REQ-1:0] dbl_s;
   logic [2*NUM_REQ-1:0] masked_s;

   // Mask off lower-half positions below ptr, then take the lowest set bit.
   always_comb begin
      dbl_s    = {req, req};
      masked_s = '0;
      found    = 1'b0;
      winner   = '0;
      for (int j = 0; j < 2*NUM_REQ; j++) begin
         masked_s[j] = dbl_s[j] & (j >= int'(ptr));
      end
      // Scan from the top so the lowest set position is the last one written.
      for (int j = 2*NUM_REQ-1; j >= 0; j--) begin
         winner = masked_s[j] ? ID_WIDTH'(j % NUM_REQ) : winner;
         found  = found | masked_s[j];
      end
   end

endmodule

// File: rtl/rr_pipe_arb.sv
// Round-robin arbiter with packet lock feeding one registered valid/ready
// output stage. A grant is held from a packet's first beat through its last
// beat; the output register gives one cycle of latency at full throughput.
module rr_pipe_arb
   import rr_pipe_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          pout_valid,
   output logic [DATA_WIDTH-1:0]         pout_data,
   output logic [ID_WIDTH-1:0]           pout_id,
   output logic                          pout_last,
   input  logic                          pout_ready
);

   logic [0:0]            state_r;
   logic [ID_WIDTH-1:0]   ptr_r;
   logic [ID_WIDTH-1:0]   lock_id_r;
   logic                  valid_r;
   logic [DATA_WIDTH-1:0] data_r;
   logic [ID_WIDTH-1:0]   id_r;
   logic                  last_r;

   logic                  stage_ready_s;
   logic                  found_s;
   logic [ID_WIDTH-1:0]   winner_s;
   logic                  lock_valid_s;
   logic [ID_WIDTH-1:0]   sel_s;
   logic                  sel_valid_s;
   logic [DATA_WIDTH-1:0] beat_data_s;
   logic                  beat_last_s;
   logic [NUM_REQ-1:0]    req_ready_s;
   logic                  fire_s;

   rr_arb_pick #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_pick (
      .req    (req_valid),
      .ptr    (ptr_r),
      .found  (found_s),
      .winner (winner_s)
   );

   // Choose the candidate: the locked owner while a packet is open, else the RR winner.
   always_comb begin
      stage_ready_s = ~valid_r | pout_ready;
      lock_valid_s  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         lock_valid_s = lock_valid_s | (req_valid[i] & (lock_id_r == ID_WIDTH'(i)));
      end
      if (state_r == ARB_LOCKED) begin
         sel_s       = lock_id_r;
         sel_valid_s = lock_valid_s;
      end else begin
         sel_s       = winner_s;
         sel_valid_s = found_s;
      end
   end

   // Steer the selected payload and raise a one-hot ready (never data-dependent).
   always_comb begin
      beat_data_s = '0;
      beat_last_s = 1'b0;
      req_ready_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         beat_data_s    = (sel_s == ID_WIDTH'(i)) ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : beat_data_s;
         beat_last_s    = (sel_s == ID_WIDTH'(i)) ? req_last[i] : beat_last_s;
         req_ready_s[i] = stage_ready_s & sel_valid_s & (sel_s == ID_WIDTH'(i));
      end
      fire_s = |req_ready_s;
   end

   // Output register: load on accept, clear when draining empty, hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         data_r  <= '0;
         id_r    <= '0;
         last_r  <= 1'b0;
      end else if (stage_ready_s) begin
         valid_r <= fire_s;
         data_r  <= fire_s ? beat_data_s : '0;
         id_r    <= fire_s ? sel_s : '0;
         last_r  <= fire_s & beat_last_s;
      end else begin
         valid_r <= valid_r;
         data_r  <= data_r;
         id_r    <= id_r;
         last_r  <= last_r;
      end
   end

   // Arbitration FSM: lock on a non-last beat, advance the pointer only on packet end.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ARB_IDLE;
         ptr_r     <= '0;
         lock_id_r <= '0;
      end else if (fire_s) begin
         case (state_r)
            ARB_IDLE: begin
               if (beat_last_s) begin
                  ptr_r <= ID_WIDTH'(next_idx(IDX_W'(sel_s), IDX_W'(NUM_REQ)));
               end else begin
                  state_r   <= ARB_LOCKED;
                  lock_id_r <= sel_s;
               end
            end
            ARB_LOCKED: begin
               if (beat_last_s) begin
                  state_r <= ARB_IDLE;
                  ptr_r   <= ID_WIDTH'(next_idx(IDX_W'(lock_id_r), IDX_W'(NUM_REQ)));
               end else begin
                  state_r <= state_r;
               end
            end
            default: begin
               state_r <= ARB_IDLE;
            end
         endcase
      end else begin
         state_r <= state_r;
      end
   end

   assign req_ready  = req_ready_s;
   assign pout_valid = valid_r;
   assign pout_data  = data_r;
   assign pout_id    = id_r;
   assign pout_last  = last_r;

endmodule

// File: tb/tb_rr_pipe_arb.sv
// Directed self-checking bench for rr_pipe_arb: a 4-requester instance for
// fairness, locking, backpressure and reset, plus a 3-requester instance for
// non-power-of-two wrap-around.
module tb_rr_pipe_arb;

   logic         clk;
   logic         rst;
   logic [3:0]   req_valid;
   logic [127:0] req_data;
   logic [3:0]   req_last;
   logic [3:0]   req_ready;
   logic         pout_valid;
   logic [31:0]  pout_data;
   logic [1:0]   pout_id;
   logic         pout_last;
   logic         pout_ready;

   logic [2:0]   r3_valid;
   logic [95:0]  r3_data;
   logic [2:0]   r3_last;
   logic [2:0]   r3_ready;
   logic         p3_valid;
   logic [31:0]  p3_data;
   logic [1:0]   p3_id;
   logic         p3_last;
   logic         p3_ready;

   int n_checks = 0;
   int n_pass   = 0;

   rr_pipe_arb #(.DATA_WIDTH(32), .NUM_REQ(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .pout_valid(pout_valid),
      .pout_data(pout_data), .pout_id(pout_id), .pout_last(pout_last),
      .pout_ready(pout_ready)
   );

   rr_pipe_arb #(.DATA_WIDTH(32), .NUM_REQ(3)) dut3 (
      .clk(clk), .rst(rst), .req_valid(r3_valid), .req_data(r3_data),
      .req_last(r3_last), .req_ready(r3_ready), .pout_valid(p3_valid),
      .pout_data(p3_data), .pout_id(p3_id), .pout_last(p3_last),
      .pout_ready(p3_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = 4'b0000; req_data = '0; req_last = 4'b0000; pout_ready = 1'b1;
      r3_valid = 3'b000; r3_data = '0; r3_last = 3'b000; p3_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (pout_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", pout_valid); else n_pass++;
      n_checks++; if (pout_data !== 32'h0) $display("FAIL reset_data: got %h expected 0", pout_data); else n_pass++;
      n_checks++; if (pout_id !== 2'd0 || pout_last !== 1'b0) $display("FAIL reset_id_last: got %0d/%b expected 0/0", pout_id, pout_last); else n_pass++;
      n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", req_ready); else n_pass++;
   endtask

   task automatic test_fairness();
      logic [3:0] exp_rdy;
      logic [1:0] exp_id;
      do_reset();
      req_valid = 4'b1111; req_last = 4'b1111;
      for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h100 + 32'(i);
      #1;
      for (int k = 0; k < 7; k++) begin
         exp_rdy = 4'b0001 << (k % 4);
         n_checks++; if (req_ready !== exp_rdy) $display("FAIL fair_ready c%0d: got %b expected %b", k, req_ready, exp_rdy); else n_pass++;
         if (k >= 1) begin
            exp_id = 2'((k - 1) % 4);
            n_checks++;
            if (pout_valid !== 1'b1 || pout_id !== exp_id || pout_data !== (32'h100 + 32'(exp_id)))
               $display("FAIL fair_out c%0d: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h", k, pout_valid, pout_id, pout_data, exp_id, 32'h100 + 32'(exp_id));
            else n_pass++;
         end else begin
            n_checks++; if (pout_valid !== 1'b0) $display("FAIL fair_first: got %b expected 0", pout_valid); else n_pass++;
         end
         tick();
      end
      req_valid = 4'b0000;
      tick();
      n_checks++; if (pout_valid !== 1'b0 || pout_data !== 32'h0) $display("FAIL fair_drain: got v=%b d=%h expected 0/0", pout_valid, pout_data); else n_pass++;
   endtask

   task automatic test_packet_lock();
      do_reset();
      req_data[0*32 +: 32] = 32'hA0; req_data[2*32 +: 32] = 32'hC0;
      req_valid = 4'b0010; req_last = 4'b0000; req_data[1*32 +: 32] = 32'hA1;
      #1;
      n_checks++; if (req_ready !== 4'b0010) $display("FAIL lock_b1_ready: got %b expected 0010", req_ready); else n_pass++;
      tick();
      req_valid = 4'b0111; req_last = 4'b0101; req_data[1*32 +: 32] = 32'hA2;
      #1;
      n_checks++; if (req_ready !== 4'b0010) $display("FAIL lock_b2_ready: got %b expected 0010", req_ready); else n_pass++;
      n_checks++; if (pout_id !== 2'd1 || pout_data !== 32'hA1 || pout_last !== 1'b0) $display("FAIL lock_b1_out: got id=%0d d=%h l=%b expected 1/a1/0", pout_id, pout_data, pout_last); else n_pass++;
      tick();
      req_last = 4'b0111; req_data[1*32 +: 32] = 32'hA3;
      #1;
      n_checks++; if (req_ready !== 4'b0010) $display("FAIL lock_b3_ready: got %b expected 0010", req_ready); else n_pass++;
      n_checks++; if (pout_id !== 2'd1 || pout_data !== 32'hA2) $display("FAIL lock_b2_out: got id=%0d d=%h expected 1/a2", pout_id, pout_data); else n_pass++;
      tick();
      req_valid = 4'b0101;
      #1;
      n_checks++; if (req_ready !== 4'b0100) $display("FAIL lock_next2_ready: got %b expected 0100", req_ready); else n_pass++;
      n_checks++; if (pout_id !== 2'd1 || pout_data !== 32'hA3 || pout_last !== 1'b1) $display("FAIL lock_b3_out: got id=%0d d=%h l=%b expected 1/a3/1", pout_id, pout_data, pout_last); else n_pass++;
      tick();
      req_valid = 4'b0001;
      #1;
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL lock_next0_ready: got %b expected 0001", req_ready); else n_pass++;
      n_checks++; if (pout_id !== 2'd2 || pout_data !== 32'hC0) $display("FAIL lock_req2_out: got id=%0d d=%h expected 2/c0", pout_id, pout_data); else n_pass++;
      tick();
      req_valid = 4'b0000;
      #1;
      n_checks++; if (pout_id !== 2'd0 || pout_data !== 32'hA0 || pout_valid !== 1'b1) $display("FAIL lock_req0_out: got v=%b id=%0d d=%h expected 1/0/a0", pout_valid, pout_id, pout_data); else n_pass++;
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      req_valid = 4'b0001; req_last = 4'b0001; req_data[0*32 +: 32] = 32'hDEADBEEF;
      tick();
      pout_ready = 1'b0; req_data[0*32 +: 32] = 32'h11111111;
      #1;
      for (int k = 0; k < 5; k++) begin
         n_checks++; if (pout_valid !== 1'b1 || pout_data !== 32'hDEADBEEF) $display("FAIL bp_hold c%0d: got v=%b d=%h expected 1/deadbeef", k, pout_valid, pout_data); else n_pass++;
         n_checks++; if (req_ready !== 4'b0000) $display("FAIL bp_ready c%0d: got %b expected 0000", k, req_ready); else n_pass++;
         tick();
      end
      pout_ready = 1'b1;
      #1;
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL bp_release_ready: got %b expected 0001", req_ready); else n_pass++;
      tick();
      req_valid = 4'b0000;
      #1;
      n_checks++; if (pout_valid !== 1'b1 || pout_data !== 32'h11111111) $display("FAIL bp_no_bubble: got v=%b d=%h expected 1/11111111", pout_valid, pout_data); else n_pass++;
      tick();
   endtask

   task automatic test_lock_idle_owner();
      do_reset();
      req_valid = 4'b1000; req_last = 4'b0000; req_data[3*32 +: 32] = 32'h33;
      #1;
      n_checks++; if (req_ready !== 4'b1000) $display("FAIL idle_own_first: got %b expected 1000", req_ready); else n_pass++;
      tick();
      req_valid = 4'b0001; req_last = 4'b0001; req_data[0*32 +: 32] = 32'h0A;
      #1;
      for (int k = 0; k < 4; k++) begin
         n_checks++; if (req_ready !== 4'b0000) $display("FAIL idle_own_block c%0d: got %b expected 0000", k, req_ready); else n_pass++;
         if (k >= 1) begin
            n_checks++; if (pout_valid !== 1'b0 || pout_data !== 32'h0) $display("FAIL idle_own_empty c%0d: got v=%b d=%h expected 0/0", k, pout_valid, pout_data); else n_pass++;
         end else begin
            n_checks++; if (pout_id !== 2'd3 || pout_data !== 32'h33) $display("FAIL idle_own_b1: got id=%0d d=%h expected 3/33", pout_id, pout_data); else n_pass++;
         end
         tick();
      end
      req_valid = 4'b1001; req_last = 4'b1001; req_data[3*32 +: 32] = 32'h34;
      #1;
      n_checks++; if (req_ready !== 4'b1000) $display("FAIL idle_own_resume: got %b expected 1000", req_ready); else n_pass++;
      tick();
      req_valid = 4'b0001;
      #1;
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL idle_own_next0: got %b expected 0001", req_ready); else n_pass++;
      n_checks++; if (pout_id !== 2'd3 || pout_data !== 32'h34 || pout_last !== 1'b1) $display("FAIL idle_own_b2: got id=%0d d=%h l=%b expected 3/34/1", pout_id, pout_data, pout_last); else n_pass++;
      tick();
      req_valid = 4'b0000;
      #1;
      n_checks++; if (pout_id !== 2'd0 || pout_data !== 32'h0A) $display("FAIL idle_own_req0: got id=%0d d=%h expected 0/0a", pout_id, pout_data); else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      req_valid = 4'b0001; req_last = 4'b0000; req_data[0*32 +: 32] = 32'h55;
      tick();
      n_checks++; if (pout_valid !== 1'b1) $display("FAIL rstmid_pre: got %b expected 1", pout_valid); else n_pass++;
      rst = 1'b1;
      req_valid = 4'b0100; req_last = 4'b0100; req_data[2*32 +: 32] = 32'h77;
      tick();
      n_checks++; if (pout_valid !== 1'b0 || pout_data !== 32'h0 || pout_id !== 2'd0 || pout_last !== 1'b0)
         $display("FAIL rstmid_out: got v=%b d=%h id=%0d l=%b expected 0/0/0/0", pout_valid, pout_data, pout_id, pout_last);
      else n_pass++;
      rst = 1'b0;
      #1;
      n_checks++; if (req_ready !== 4'b0100) $display("FAIL rstmid_unlocked: got %b expected 0100", req_ready); else n_pass++;
      tick();
      req_valid = 4'b0000;
      #1;
      n_checks++; if (pout_valid !== 1'b1 || pout_id !== 2'd2 || pout_data !== 32'h77) $display("FAIL rstmid_req2: got v=%b id=%0d d=%h expected 1/2/77", pout_valid, pout_id, pout_data); else n_pass++;
      tick();
   endtask

   task automatic test_wrap_np2();
      do_reset();
      r3_data[0*32 +: 32] = 32'hB0; r3_data[1*32 +: 32] = 32'hB1; r3_last = 3'b111;
      r3_valid = 3'b010;
      #1;
      n_checks++; if (r3_ready !== 3'b010 || p3_data !== 32'h0) $display("FAIL wrap_setup: got rdy=%b d=%h expected 010/0", r3_ready, p3_data); else n_pass++;
      tick();
      r3_valid = 3'b011;
      #1;
      n_checks++; if (r3_ready !== 3'b001) $display("FAIL wrap_to0: got %b expected 001", r3_ready); else n_pass++;
      tick();
      #1;
      n_checks++; if (r3_ready !== 3'b010) $display("FAIL wrap_then1: got %b expected 010", r3_ready); else n_pass++;
      n_checks++; if (p3_valid !== 1'b1 || p3_id !== 2'd0 || p3_data !== 32'hB0) $display("FAIL wrap_out0: got v=%b id=%0d d=%h expected 1/0/b0", p3_valid, p3_id, p3_data); else n_pass++;
      tick();
      r3_valid = 3'b000;
      #1;
      n_checks++; if (p3_id !== 2'd1 || p3_data !== 32'hB1) $display("FAIL wrap_out1: got id=%0d d=%h expected 1/b1", p3_id, p3_data); else n_pass++;
      tick();
      n_checks++; if (p3_valid !== 1'b0 || p3_data !== 32'h0 || p3_id !== 2'd0) $display("FAIL wrap_empty: got v=%b d=%h id=%0d expected 0/0/0", p3_valid, p3_data, p3_id); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_packet_lock();
      test_backpressure();
      test_lock_idle_owner();
      test_reset_mid_packet();
      test_wrap_np2();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rr_pipe_arb.md
Name: rr_pipe_arb

Overview:
- Shares one registered valid/ready output channel between NUM_REQ requesters using round-robin arbitration with packet lock.
- A grant is held from the first beat of a packet through its `last` beat, so packets from different requesters never interleave.
- The output stage is a single-entry valid/ready register: one cycle of latency, full throughput when downstream is ready.
- Sits in front of a shared pipeline resource, e.g. a memory or writeback port fed by several pipeline stages.

Parameters:
- DATA_WIDTH, 32, payload width per requester.
- NUM_REQ, 4, number of requesters; legal range 2..16.
- ID_WIDTH, $clog2(NUM_REQ), width of the granted-requester index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  per-requester last-beat-of-packet flag.
- req_ready  out  NUM_REQ  per-requester ready; one-hot or zero.
- pout_valid  out  1  output valid.
- pout_data  out  DATA_WIDTH  output payload; forced to 0 when pout_valid=0.
- pout_id  out  ID_WIDTH  index of the requester that sourced the beat; 0 when invalid.
- pout_last  out  1  last flag of the beat; 0 when invalid.
- pout_ready  in  1  downstream ready.

Behaviour:
- Reset: pout_valid=0, pout_data=0, pout_id=0, pout_last=0, req_ready=0, state=IDLE, priority pointer=0.
- Stage accept: stage_ready = ~valid_q | pout_ready, the same rule as the codebase's pipe stage.
- Beat transfer: beat i transfers when req_valid[i] & req_ready[i]. The registered output is valid on the next cycle (latency 1).
- req_ready[i] = stage_ready & (i == selected requester) & req_valid[i].
- req_ready never depends combinationally on req_data or req_last.
- FSM states: IDLE and LOCKED.
- IDLE:
  - Selection is the first requester with req_valid set, searching cyclically from ptr (ptr, ptr+1, ... wrapping modulo NUM_REQ).
  - On a transfer with req_last=1: stay in IDLE; ptr <= winner+1 mod NUM_REQ.
  - On a transfer with req_last=0: go to LOCKED; lock_id <= winner.
- LOCKED:
  - Selection is fixed to lock_id. Other requesters see req_ready=0 even if lock_id is idle, i.e. its req_valid is low.
  - A transfer from lock_id with req_last=1: go to IDLE; ptr <= lock_id+1 mod NUM_REQ.
- The pointer updates only on a packet-ending transfer. If there are no requests, or the stage is stalled, ptr and state are unchanged.
- Stall: while pout_valid=1 & pout_ready=0, the output register holds pout_data, pout_id and pout_last stable, and no req_ready is asserted.
- Simultaneous drain and load: when pout_ready=1 and a new beat is accepted in the same cycle, the register is replaced. There is no bubble, so sustained throughput is 1 beat/cycle.
- Empty pipe: when valid_q=0 and no request is present, pout_valid falls to 0 after the current beat drains.
- Reset mid-packet: LOCKED state is abandoned and any held output beat is dropped. Requesters must restart the packet after reset.
- Requester protocol:
  - A requester must hold req_valid and its payload stable until accepted.
  - The arbiter does not check this; violations are an assertion failure in the bench.
- Wrap-around: ptr = NUM_REQ-1 followed by a grant wraps to 0. The search must wrap correctly for NUM_REQ not a power of two.

Decomposition:
- Shared package:
  - FSM state enum (ARB_IDLE, ARB_LOCKED).
  - A function for cyclic next-index: (idx+1) mod NUM_REQ.
- One sub-module is natural: rr_arb_pick.
  - Purely combinational.
  - Takes req vector and ptr; returns found flag and winner index.
  - Implemented as a double-width masked priority search.
- The top level holds the FSM, ptr, lock_id and the output register.

Test Plan:
- Fairness: NUM_REQ=4, all req_valid=1 with single-beat packets (last=1), pout_ready=1 -> pout_id sequence 0,1,2,3,0,1 with pout_valid=1 every cycle after the first.
- Packet lock: req 1 sends a 3-beat packet (last on beat 3) while req 0 and req 2 are valid -> pout_id=1,1,1, then 2, then 0. Req 0 and req 2 see req_ready=0 during the packet.
- Backpressure: pout_ready=0 for 5 cycles with beat 0xDEADBEEF held -> pout_data stays 0xDEADBEEF, all req_ready=0. On release, the next beat follows with no bubble.
- Lock with idle owner: req 3 sends one non-last beat, then deasserts req_valid for 4 cycles while req 0 is valid -> no grant to req 0. When req 3 resumes with last, req 0 wins next.
- Reset mid-packet: assert rst in LOCKED with pout_valid=1 -> next cycle pout_valid=0, pout_data=0, state IDLE, ptr=0. Req 2 alone then wins with pout_id=2.
- Wrap/non-power-of-two: NUM_REQ=3, ptr=2, req_valid=3'b011 -> winner 0, then 1. pout_data=0 whenever pout_valid=0.
